seg7_scan_driver_param: RTL and testbench

//  Parametrised multi-channel hex display driver: the successor to the fixed
//  16x16-bit, 8-group display path.

---
 rtl/seg7_scan_driver_param.sv | 196 +++++++++++++++++++
 tb/tb_seg7_scan_driver_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_param.sv
// seg7_scan_driver_param
//   Multi-channel hex display driver. NUM_CH values of DATA_W bits are decoded
//   into 7-segment + DP patterns and time-multiplexed onto NUM_GRP parallel
//   segment buses that share NUM_SEL scan selects. A frame snapshot keeps the
//   display tear-free, FREEZE holds the snapshot, leading zeros can be blanked,
//   BRIGHT sets PWM duty per slot and pre_cnt == 0 is always dark so segment
//   changes never show as ghosting.
//
//   Constraints: DATA_W multiple of 4, NUM_CH*DATA_W/4 == NUM_GRP*NUM_SEL,
//   SCAN_DIV >= 4.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   data        channel c at [c*DATA_W +: DATA_W]
//   dp_mask     decimal point per digit, bit k = global digit k
//   blank_lz    enable leading-zero blanking (snapshotted)
//   bright      brightness, 0 = 1/16 duty, 15 = full (sampled live)
//   freeze      1 = hold current snapshot
//   seg         group g at [g*8 +: 8]; bit0 = a .. bit6 = g, bit7 = dp
//   seg_sel     one-hot scan select (in output polarity)
//   frame_tick  one-cycle pulse after each snapshot load

module seg7_scan_driver_param #(
   parameter int DATA_W      = 16,
   parameter int NUM_CH      = 16,
   parameter int NUM_GRP     = 8,
   parameter int NUM_SEL     = 8,
   parameter int SCAN_DIV    = 1000,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH*DATA_W-1:0]      data,
   input  logic [NUM_CH*(DATA_W/4)-1:0]  dp_mask,
   input  logic                          blank_lz,
   input  logic [3:0]                    bright,
   input  logic                          freeze,
   output logic [NUM_GRP*8-1:0]          seg,
   output logic [NUM_SEL-1:0]            seg_sel,
   output logic                          frame_tick
);

   localparam int DIG   = DATA_W / 4;
   localparam int NDIG  = NUM_CH * DIG;
   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int SEL_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SEL - 1);
   localparam logic POL = (SEG_ACT_LOW != 0);

   logic [PRE_W-1:0]          pre_cnt;
   logic [SEL_W-1:0]          sel_idx;
   logic                      first_q;
   logic                      pre_wrap;
   logic                      sel_wrap;
   logic                      frame_start;
   logic                      load;

   logic [NUM_CH*DATA_W-1:0]  shd_data;
   logic [NDIG-1:0]           shd_dp;
   logic                      shd_blz;
   logic                      tick_q;

   logic [3:0]                dig_nib   [NUM_GRP][NUM_SEL];
   logic                      dig_blank [NUM_GRP][NUM_SEL];
   logic                      dig_dp    [NUM_GRP][NUM_SEL];

   logic [NUM_GRP*8-1:0]      seg_nxt;
   logic [NUM_SEL-1:0]        sel_nxt;
   logic [31:0]               thr;
   logic                      sel_en;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'h0:    p = 7'h3F;
         4'h1:    p = 7'h06;
         4'h2:    p = 7'h5B;
         4'h3:    p = 7'h4F;
         4'h4:    p = 7'h66;
         4'h5:    p = 7'h6D;
         4'h6:    p = 7'h7D;
         4'h7:    p = 7'h07;
         4'h8:    p = 7'h7F;
         4'h9:    p = 7'h6F;
         4'hA:    p = 7'h77;
         4'hB:    p = 7'h7C;
         4'hC:    p = 7'h39;
         4'hD:    p = 7'h5E;
         4'hE:    p = 7'h79;
         default: p = 7'h71;
      endcase
      return p;
   endfunction

   // ---------------------------------------------------------------- scan
   assign pre_wrap = (pre_cnt == PRE_LAST);
   assign sel_wrap = (sel_idx == SEL_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
         sel_idx <= '0;
         first_q <= 1'b1;
      end else begin
         first_q <= 1'b0;
         if (pre_wrap) begin
            pre_cnt <= '0;
            sel_idx <= sel_wrap ? '0 : sel_idx + SEL_W'(1);
         end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
      end
   end

   // ------------------------------------------------------------ snapshot
   // first_q forces a load on the first cycle out of reset so the display
   // does not sit on the all-zero shadow for a whole frame.
   assign frame_start = first_q || (pre_wrap && sel_wrap);
   assign load        = frame_start && !freeze;

   always_ff @(posedge clk) begin
      if (rst) begin
         shd_data <= '0;
         shd_dp   <= '0;
         shd_blz  <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         tick_q <= load;
         if (load) begin
            shd_data <= data;
            shd_dp   <= dp_mask;
            shd_blz  <= blank_lz;
         end
      end
   end

   assign frame_tick = tick_q;

   // --------------------------------------------------------- digit map
   // Every (group, select) slot maps to a fixed digit, so the nibble, the
   // blank flag and the DP bit are all static selects of the shadow. A digit
   // is a leading zero when the top 4*(n+1) bits of its channel are zero.
   for (genvar g = 0; g < NUM_GRP; g++) begin : g_map
      for (genvar s = 0; s < NUM_SEL; s++) begin : g_slot
         localparam int K   = g * NUM_SEL + s;
         localparam int C   = K / DIG;
         localparam int N   = K % DIG;
         localparam int TOP = C * DATA_W + DATA_W - 1;
         assign dig_nib[g][s]   = shd_data[TOP - 4*N -: 4];
         assign dig_blank[g][s] = shd_blz && (N < DIG - 1) &&
                                  (shd_data[TOP -: 4*(N+1)] == '0);
         assign dig_dp[g][s]    = shd_dp[K];
      end
   end

   for (genvar g = 0; g < NUM_GRP; g++) begin : g_dec
      logic [3:0] nib;
      logic       blank;
      logic       dp;
      assign nib   = dig_nib[g][sel_idx];
      assign blank = dig_blank[g][sel_idx];
      assign dp    = dig_dp[g][sel_idx];
      assign seg_nxt[g*8 +: 8] = {dp, blank ? 7'h00 : hex7(nib)};
   end

   // ------------------------------------------------------ select enable
   // Slot is lit for 1 <= pre_cnt < thr. thr is clamped so even the lowest
   // brightness keeps one lit cycle per slot.
   always_comb begin
      thr = ((32'(bright) + 32'd1) * 32'(SCAN_DIV)) >> 4;
      if (thr < 32'd2) begin
         thr = 32'd2;
      end
      sel_en  = (pre_cnt != '0) && (32'(pre_cnt) < thr);
      sel_nxt = '0;
      if (sel_en) begin
         sel_nxt[sel_idx] = 1'b1;
      end
   end

   // ---------------------------------------------------- output registers
   // seg follows sel_idx, which only moves as pre_cnt wraps to 0; that cycle
   // is always dark, so segment updates happen with every select off.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg     <= {(NUM_GRP*8){POL}};
         seg_sel <= {NUM_SEL{POL}};
      end else begin
         seg     <= seg_nxt ^ {(NUM_GRP*8){POL}};
         seg_sel <= sel_nxt ^ {NUM_SEL{POL}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver_param.sv
module tb_seg7_scan_driver_param;

   localparam int DATA_W   = 16;
   localparam int NUM_CH   = 2;
   localparam int NUM_GRP  = 2;
   localparam int NUM_SEL  = 4;
   localparam int SCAN_DIV = 8;
   localparam int DIG      = DATA_W / 4;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [NUM_CH*DATA_W-1:0]    data;
   logic [NUM_CH*DIG-1:0]       dp_mask;
   logic                        blank_lz;
   logic [3:0]                  bright;
   logic                        freeze;
   logic [NUM_GRP*8-1:0]        seg,        seg_n;
   logic [NUM_SEL-1:0]          seg_sel,    seg_sel_n;
   logic                        frame_tick, frame_tick_n;

   int total = 0;
   int bad   = 0;
   int ph    = 0;
   logic [31:0] exp_q[$];

   seg7_scan_driver_param #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .NUM_GRP(NUM_GRP), .NUM_SEL(NUM_SEL),
      .SCAN_DIV(SCAN_DIV), .SEG_ACT_LOW(0)
   ) dut (
      .clk(clk), .rst(rst), .data(data), .dp_mask(dp_mask), .blank_lz(blank_lz),
      .bright(bright), .freeze(freeze), .seg(seg), .seg_sel(seg_sel),
      .frame_tick(frame_tick)
   );

   seg7_scan_driver_param #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .NUM_GRP(NUM_GRP), .NUM_SEL(NUM_SEL),
      .SCAN_DIV(SCAN_DIV), .SEG_ACT_LOW(1)
   ) dut_n (
      .clk(clk), .rst(rst), .data(data), .dp_mask(dp_mask), .blank_lz(blank_lz),
      .bright(bright), .freeze(freeze), .seg(seg_n), .seg_sel(seg_sel_n),
      .frame_tick(frame_tick_n)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   // Expected outputs for both polarities, queued in compare order.
   task automatic exp_out(input logic [15:0] s, input logic [3:0] sl, input logic t);
      logic [15:0] sn;
      logic [3:0]  sln;
      sn  = ~s;
      sln = ~sl;
      push({16'h0, s});
      push({28'h0, sl});
      push({16'h0, sn});
      push({28'h0, sln});
      push({31'h0, t});
      push({31'h0, t});
   endtask

   task automatic chk_out(input string tag);
      chk({tag, "_seg"},      {16'h0, seg});
      chk({tag, "_sel"},      {28'h0, seg_sel});
      chk({tag, "_seg_n"},    {16'h0, seg_n});
      chk({tag, "_sel_n"},    {28'h0, seg_sel_n});
      chk({tag, "_tick"},     {31'h0, frame_tick});
      chk({tag, "_tick_n"},   {31'h0, frame_tick_n});
   endtask

   task automatic adv_to(input int d);
      while (ph < d) begin
         @(negedge clk);
         ph++;
      end
   endtask

   // After a tick from a frame wrap, position d maps to slot (d-1)/8, pre (d-1)%8.
   task automatic wait_tick(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 100);
      ph = 0;
      total++;
      assert (frame_tick === 1'b1) else begin
         bad++;
         $error("FAIL %s observed=%b expected=1", tag, frame_tick);
      end
   endtask

   initial begin
      int cnt[4];
      int onehot_err;
      int ticks;

      rst = 1'b1; data = '0; dp_mask = '0; blank_lz = 1'b0;
      bright = 4'd15; freeze = 1'b0;

      // ---- reset state and release
      exp_out(16'h0000, 4'b0000, 1'b0);
      repeat (3) @(negedge clk);
      chk_out("rst_hold");
      rst = 1'b0;
      exp_out(16'h3F3F, 4'b0000, 1'b1);
      @(negedge clk);
      chk_out("rst_rel1");
      exp_out(16'h3F3F, 4'b0001, 1'b0);
      @(negedge clk);
      chk_out("rst_rel2");

      // ---- decode
      data = {16'h89AB, 16'h0123};
      wait_tick("dec_load");
      exp_out(16'h7F3F, 4'b0000, 1'b0); adv_to(1);  chk_out("dec_s0_gap");
      exp_out(16'h7F3F, 4'b0001, 1'b0); adv_to(2);  chk_out("dec_s0");
      exp_out(16'h6F06, 4'b0010, 1'b0); adv_to(10); chk_out("dec_s1");
      exp_out(16'h775B, 4'b0100, 1'b0); adv_to(18); chk_out("dec_s2");
      exp_out(16'h7C4F, 4'b1000, 1'b0); adv_to(26); chk_out("dec_s3");
      wait_tick("dec_tick2");
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      onehot_err = 0;
      for (int d = 1; d <= 32; d++) begin
         adv_to(d);
         if (seg_sel !== 4'b0000) begin
            cnt[(d-1)/8]++;
            if (seg_sel !== (4'b0001 << ((d-1)/8))) onehot_err++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         push(32'd7);
         chk($sformatf("duty_full_s%0d", i), cnt[i]);
      end
      push(32'd0);
      chk("sel_onehot", onehot_err);

      // ---- leading-zero blanking
      data = {16'h89AB, 16'h0007}; blank_lz = 1'b1;
      wait_tick("lz_load1");
      exp_out(16'h7F00, 4'b0001, 1'b0); adv_to(2);  chk_out("lz7_s0");
      exp_out(16'h6F00, 4'b0010, 1'b0); adv_to(10); chk_out("lz7_s1");
      exp_out(16'h7700, 4'b0100, 1'b0); adv_to(18); chk_out("lz7_s2");
      exp_out(16'h7C07, 4'b1000, 1'b0); adv_to(26); chk_out("lz7_s3");
      data = {16'h89AB, 16'h0000}; dp_mask = 8'h82;
      wait_tick("lz_load2");
      exp_out(16'h6F80, 4'b0010, 1'b0); adv_to(10); chk_out("lz0_dp_s1");
      exp_out(16'hFC3F, 4'b1000, 1'b0); adv_to(26); chk_out("lz0_dp_s3");
      data = {16'h89AB, 16'h0102}; dp_mask = 8'h00;
      wait_tick("lz_load3");
      exp_out(16'h7F00, 4'b0001, 1'b0); adv_to(2);  chk_out("lz102_s0");
      exp_out(16'h773F, 4'b0100, 1'b0); adv_to(18); chk_out("lz102_s2");
      exp_out(16'h7C5B, 4'b1000, 1'b0); adv_to(26); chk_out("lz102_s3");

      // ---- tear-free update
      data = {16'hCAFE, 16'h1234}; blank_lz = 1'b0;
      wait_tick("tf_load");
      adv_to(10);
      data = {16'h5555, 16'h6666};
      exp_out(16'h7966, 4'b1000, 1'b0); adv_to(26); chk_out("tf_hold_s3");
      wait_tick("tf_next");
      exp_out(16'h6D7D, 4'b0001, 1'b0); adv_to(2); chk_out("tf_new_s0");

      // ---- freeze raised on the frame-start cycle, held 3+ frames
      adv_to(31);
      freeze = 1'b1;
      data = {16'hDEAD, 16'hBEEF};
      ticks = 0;
      for (int d = 32; d <= 130; d++) begin
         adv_to(d);
         if (frame_tick !== 1'b0 || frame_tick_n !== 1'b0) ticks++;
      end
      push(32'd0);
      chk("frz_ticks", ticks);
      exp_out(16'h6D7D, 4'b0001, 1'b0);
      chk_out("frz_old");
      freeze = 1'b0;
      wait_tick("frz_release");
      exp_out(16'h5E7C, 4'b0001, 1'b0); adv_to(2);  chk_out("frz_new_s0");
      exp_out(16'h5E71, 4'b1000, 1'b0); adv_to(26); chk_out("frz_new_s3");

      // ---- brightness
      bright = 4'd0;
      wait_tick("br_frame");
      cnt[1] = 0;
      exp_out(16'h7979, 4'b0010, 1'b0);
      exp_out(16'h7979, 4'b0000, 1'b0);
      for (int d = 9; d <= 16; d++) begin
         adv_to(d);
         if (seg_sel !== 4'b0000) cnt[1]++;
         if (d == 10) chk_out("br0_p1");
         if (d == 11) chk_out("br0_p2");
      end
      push(32'd1);
      chk("br0_count", cnt[1]);
      adv_to(20);
      bright = 4'd7;
      cnt[3] = 0;
      exp_out(16'h5E71, 4'b1000, 1'b0);
      exp_out(16'h5E71, 4'b0000, 1'b0);
      for (int d = 25; d <= 32; d++) begin
         adv_to(d);
         if (seg_sel !== 4'b0000) cnt[3]++;
         if (d == 28) chk_out("br7_p3");
         if (d == 29) chk_out("br7_p4");
      end
      push(32'd3);
      chk("br7_count", cnt[3]);

      // ---- reset mid-slot
      bright = 4'd15;
      adv_to(36);
      rst = 1'b1;
      exp_out(16'h0000, 4'b0000, 1'b0);
      @(negedge clk);
      chk_out("rst_mid");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_out(16'h3F3F, 4'b0000, 1'b1);
      @(negedge clk);
      chk_out("rst_mid_rel1");
      exp_out(16'h5E7C, 4'b0001, 1'b0);
      @(negedge clk);
      chk_out("rst_mid_rel2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
